// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared types and constants for the cache refill AXI read arbiter.
package cache_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RET  = 2'd3
  } ArbStateType;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } ReqSrcType;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned ARID_I = 0;
  localparam int unsigned ARID_D = 1;

  // Latched refill request: line address and owning cache
  typedef struct packed {
    logic [31:0] addr;
    ReqSrcType   src;
  } ar_req_t;

  // Line-align a refill address (low nibble forced to zero)
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// Bus bundle for the refill arbiter: both cache refill ports plus AXI AR/R.
// master = arbiter side, slave = caches and AXI slave side.
interface cache_axi_rd_arbiter_if #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ID_W       = 4
);
  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  logic              i_rd_req;
  logic [31:0]       i_rd_addr;
  logic              i_rd_rdy;
  logic              i_ret_valid;
  logic [LINE_W-1:0] i_ret_data;

  logic              d_rd_req;
  logic [31:0]       d_rd_addr;
  logic              d_rd_rdy;
  logic              d_ret_valid;
  logic [LINE_W-1:0] d_ret_data;

  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic              proto_err;

  modport master (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_data,
    output d_rd_rdy, d_ret_valid, d_ret_data,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output proto_err
  );

  modport slave (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_data,
    input  d_rd_rdy, d_ret_valid, d_ret_data,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  proto_err
  );

endinterface

// File: rtl/cache_axi_rd_arbiter_line_assembler.sv
// Beat counter and line buffer for one refill burst; flags the final beat
// and per-beat protocol errors (rlast misplaced or non-OKAY response).
module cache_axi_rd_arbiter_line_assembler
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_clr,
  input  logic                    i_beat,
  input  logic [31:0]             i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  output logic                    o_last_c,
  output logic                    o_beat_err_c,
  output logic [32*LINE_WORDS-1:0] o_line_next_c
);

  localparam int unsigned CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic [CNT_W-1:0]             r_beat_cnt;
  logic [LINE_WORDS-1:0][31:0]  r_line;
  logic [LINE_WORDS-1:0][31:0]  w_line_next;

  assign o_last_c     = (r_beat_cnt == CNT_W'(LINE_WORDS - 1));
  assign o_beat_err_c = (i_rresp != AXI_RESP_OKAY) || (i_rlast != o_last_c);

  // Line as it will look once the current beat is written (used for the final beat)
  always_comb begin
    w_line_next             = r_line;
    w_line_next[r_beat_cnt] = i_rdata;
  end

  assign o_line_next_c = w_line_next;

  // Beat counter and word insert; counter restarts each burst, rlast ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_cnt <= '0;
      r_line     <= '0;
    end else if (i_clr) begin
      r_beat_cnt <= '0;
    end else if (i_beat) begin
      r_line[r_beat_cnt] <= i_rdata;
      r_beat_cnt         <= o_last_c ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read master between the ICache and DCache refill ports.
// One refill outstanding; each refill is a single INCR burst of LINE_WORDS beats,
// returned to the owner as a full line with a one-cycle ret_valid pulse.
// Optional macro CACHE_ARB_RR_EN: round-robin tie break (default: DCache priority).
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ID_W       = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  cache_axi_rd_arbiter_if.master bus
);

  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  ArbStateType       r_state;
  ar_req_t           r_req;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_i_ret_valid;
  logic              r_d_ret_valid;
  logic              r_proto_err;
  logic [LINE_W-1:0] r_i_ret_data;
  logic [LINE_W-1:0] r_d_ret_data;

  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_idle;
  logic              w_accept;
  logic              w_beat;
  logic              w_last_c;
  logic              w_beat_err_c;
  logic [LINE_W-1:0] w_line_next_c;
  logic [31:0]       w_req_addr;
  logic              w_unused_rid;

  assign w_idle = (r_state == IDLE);

`ifdef CACHE_ARB_RR_EN
  ReqSrcType r_last_grant;

  // Round-robin: on a tie, serve the cache not granted last
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (bus.i_rd_req && bus.d_rd_req) begin
      if (r_last_grant == SRC_D) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_d = 1'b1;
      end
    end else begin
      w_grant_i = bus.i_rd_req;
      w_grant_d = bus.d_rd_req;
    end
  end

  // Remember the last accepted owner; starts at DCache so ICache wins the first tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= SRC_D;
    end else if (w_accept) begin
      r_last_grant <= w_grant_d ? SRC_D : SRC_I;
    end
  end
`else
  // Fixed priority: DCache over ICache
  always_comb begin
    w_grant_d = bus.d_rd_req;
    w_grant_i = bus.i_rd_req && !bus.d_rd_req;
  end
`endif

  assign w_accept   = w_idle && (w_grant_i || w_grant_d);
  assign w_req_addr = w_grant_d ? bus.d_rd_addr : bus.i_rd_addr;
  assign w_beat     = r_rready && bus.rvalid;

  // rid is not checked: only one transaction can be outstanding
  assign w_unused_rid = ^bus.rid;

  cache_axi_rd_arbiter_line_assembler #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_asm (
    .clk           (clk),
    .resetn        (resetn),
    .i_clr         (w_idle),
    .i_beat        (w_beat),
    .i_rdata       (bus.rdata),
    .i_rresp       (bus.rresp),
    .i_rlast       (bus.rlast),
    .o_last_c      (w_last_c),
    .o_beat_err_c  (w_beat_err_c),
    .o_line_next_c (w_line_next_c)
  );

  // Refill FSM with AR register, R ready, line return and sticky protocol error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_req.addr    <= '0;
      r_req.src     <= SRC_I;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_i_ret_valid <= 1'b0;
      r_d_ret_valid <= 1'b0;
      r_proto_err   <= 1'b0;
      r_i_ret_data  <= '0;
      r_d_ret_data  <= '0;
    end else begin
      r_i_ret_valid <= 1'b0;
      r_d_ret_valid <= 1'b0;
      if (w_beat && w_beat_err_c) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.addr <= line_addr(w_req_addr);
            r_req.src  <= w_grant_d ? SRC_D : SRC_I;
            r_arvalid  <= 1'b1;
            r_state    <= AR;
          end
        end
        AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
        end
        R: begin
          if (w_beat && w_last_c) begin
            r_rready <= 1'b0;
            r_state  <= RET;
            if (r_req.src == SRC_D) begin
              r_d_ret_valid <= 1'b1;
              r_d_ret_data  <= w_line_next_c;
            end else begin
              r_i_ret_valid <= 1'b1;
              r_i_ret_data  <= w_line_next_c;
            end
          end
        end
        RET: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_rd_rdy    = w_idle && w_grant_i;
  assign bus.d_rd_rdy    = w_idle && w_grant_d;
  assign bus.i_ret_valid = r_i_ret_valid;
  assign bus.d_ret_valid = r_d_ret_valid;
  assign bus.i_ret_data  = r_i_ret_data;
  assign bus.d_ret_data  = r_d_ret_data;

  assign bus.arid    = (r_req.src == SRC_D) ? ID_W'(ARID_D) : ID_W'(ARID_I);
  assign bus.araddr  = r_req.addr;
  assign bus.arlen   = 8'(LINE_WORDS - 1);
  assign bus.arsize  = AXI_SIZE_4B;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter; tie-break expectations follow CACHE_ARB_RR_EN.
module tb_cache_axi_rd_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_axi_rd_arbiter_if #(.LINE_WORDS(4), .ID_W(4)) bus ();

  cache_axi_rd_arbiter #(.LINE_WORDS(4), .ID_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    resetn = 1'b0;
    bus.i_rd_req = 0; bus.i_rd_addr = 0; bus.d_rd_req = 0; bus.d_rd_addr = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // AXI slave: waits for arvalid, holds arready low ar_wait cycles, returns 4 beats.
  // Returns at the negedge of the cycle following the final beat.
  task automatic axi_serve(input int ar_wait, input int r_gap, input logic [3:0][31:0] words,
                           input int rlast_beat, input logic [1:0] resp,
                           output logic [31:0] o_addr, output logic [3:0] o_id, output logic [7:0] o_len,
                           output logic [4:0] o_szb, output int o_lat, output int o_unstable,
                           output bit o_timeout);
    int n;
    n = 0; o_timeout = 0; o_unstable = 0;
    o_addr = 0; o_id = 0; o_len = 0; o_szb = 0;
    while (!bus.arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    o_lat = n;
    if (!bus.arvalid) begin
      o_timeout = 1;
      return;
    end
    o_addr = bus.araddr; o_id = bus.arid; o_len = bus.arlen; o_szb = {bus.arsize, bus.arburst};
    repeat (ar_wait) begin
      @(negedge clk);
      if (!bus.arvalid || bus.araddr !== o_addr || bus.arid !== o_id) o_unstable++;
    end
    bus.arready = 1;
    @(negedge clk);
    bus.arready = 0;
    for (int b = 0; b < 4; b++) begin
      bus.rvalid = 1; bus.rdata = words[b]; bus.rid = o_id;
      bus.rlast = (b == rlast_beat); bus.rresp = resp;
      @(negedge clk);
      bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
      if (b < 3) repeat (r_gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({bus.i_rd_rdy, bus.d_rd_rdy, bus.i_ret_valid, bus.d_ret_valid, bus.arvalid, bus.rready, bus.proto_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {bus.i_rd_rdy, bus.d_rd_rdy, bus.i_ret_valid, bus.d_ret_valid, bus.arvalid, bus.rready, bus.proto_err});
    end
    n_tests++;
    if ({bus.i_ret_data, bus.d_ret_data} !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h expected 0", bus.i_ret_data, bus.d_ret_data);
    end
  endtask

  task automatic test_single_refill();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    bus.i_rd_addr = 32'h1FC0_0014; bus.i_rd_req = 1;
    #1;
    n_tests++;
    if (bus.i_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b expected 1", bus.i_rd_rdy); end
    @(negedge clk);
    bus.i_rd_req = 0;
    axi_serve(0, 0, {32'h44, 32'h33, 32'h22, 32'h11}, 3, 2'b00, a, id, len, szb, lat, unst, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: arvalid never seen"); return; end
    n_tests++;
    if (lat !== 0) begin n_fail++; $display("FAIL single_ar_latency: got %0d expected 0", lat); end
    n_tests++;
    if ({a, id, len, szb} !== {32'h1FC0_0010, 4'd0, 8'd3, 3'b010, 2'b01}) begin
      n_fail++; $display("FAIL single_ar: got addr %h id %h len %h szb %b expected 1fc00010 0 03 01001", a, id, len, szb);
    end
    n_tests++;
    if ({bus.i_ret_valid, bus.d_ret_valid} !== 2'b10) begin n_fail++; $display("FAIL single_ret_valid: got %b expected 10", {bus.i_ret_valid, bus.d_ret_valid}); end
    n_tests++;
    if (bus.i_ret_data !== 128'h00000044_00000033_00000022_00000011) begin
      n_fail++; $display("FAIL single_ret_data: got %h expected 00000044000000330000002200000011", bus.i_ret_data);
    end
    @(negedge clk);
    n_tests++;
    if (bus.i_ret_valid !== 1'b0) begin n_fail++; $display("FAIL single_ret_pulse: got %b expected 0", bus.i_ret_valid); end
  endtask

  task automatic test_tie();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    bit first_d;
    logic [127:0] line_w, line_l;
`ifdef CACHE_ARB_RR_EN
    first_d = 0;
`else
    first_d = 1;
`endif
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      line_w = {32'hA3 + rep, 32'hA2, 32'hA1, 32'hA0};
      line_l = {32'hB3 + rep, 32'hB2, 32'hB1, 32'hB0};
      bus.i_rd_addr = 32'h0000_1008; bus.d_rd_addr = 32'h8000_123C;
      bus.i_rd_req = 1; bus.d_rd_req = 1;
      #1;
      n_tests++;
      if ({bus.i_rd_rdy, bus.d_rd_rdy} !== (first_d ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL tie%0d_grant: got i/d rdy %b expected %b", rep, {bus.i_rd_rdy, bus.d_rd_rdy}, first_d ? 2'b01 : 2'b10);
      end
      @(negedge clk);
      if (first_d) bus.d_rd_req = 0; else bus.i_rd_req = 0;
      axi_serve(0, 0, line_w, 3, 2'b00, a, id, len, szb, lat, unst, to);
      n_tests++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL tie%0d_timeout1: arvalid never seen", rep); return; end
      n_tests++;
      if ({id, a} !== {first_d ? 4'd1 : 4'd0, first_d ? 32'h8000_1230 : 32'h0000_1000}) begin
        n_fail++; $display("FAIL tie%0d_first_ar: got id %h addr %h expected first_d=%0d", rep, id, a, first_d);
      end
      n_tests++;
      if ((first_d ? bus.d_ret_valid : bus.i_ret_valid) !== 1'b1) begin n_fail++; $display("FAIL tie%0d_first_ret: got 0 expected 1", rep); end
      n_tests++;
      if ((first_d ? bus.i_rd_rdy : bus.d_rd_rdy) !== 1'b0) begin n_fail++; $display("FAIL tie%0d_rdy_in_ret: got 1 expected 0", rep); end
      @(negedge clk);
      n_tests++;
      if ((first_d ? bus.i_rd_rdy : bus.d_rd_rdy) !== 1'b1) begin n_fail++; $display("FAIL tie%0d_loser_rdy: got 0 expected 1", rep); end
      @(negedge clk);
      bus.i_rd_req = 0; bus.d_rd_req = 0;
      axi_serve(0, 0, line_l, 3, 2'b00, a, id, len, szb, lat, unst, to);
      n_tests++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL tie%0d_timeout2: arvalid never seen", rep); return; end
      n_tests++;
      if (id !== (first_d ? 4'd0 : 4'd1)) begin n_fail++; $display("FAIL tie%0d_second_id: got %h expected %h", rep, id, first_d ? 4'd0 : 4'd1); end
      n_tests++;
      if ((first_d ? bus.i_ret_data : bus.d_ret_data) !== line_l) begin n_fail++; $display("FAIL tie%0d_second_data: got wrong line expected %h", rep, line_l); end
      n_tests++;
      if ((first_d ? bus.d_ret_data : bus.i_ret_data) !== line_w) begin n_fail++; $display("FAIL tie%0d_first_held: got changed line expected %h", rep, line_w); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    int extra;
    bus.i_rd_addr = 32'h0000_0FFF; bus.i_rd_req = 1;
    @(negedge clk);
    bus.i_rd_req = 0;
    axi_serve(5, 2, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 3, 2'b00, a, id, len, szb, lat, unst, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: arvalid never seen"); return; end
    n_tests++;
    if (unst !== 0 || a !== 32'h0000_0FF0) begin n_fail++; $display("FAIL stall_ar_stable: got %0d changes addr %h expected 0 / 00000ff0", unst, a); end
    n_tests++;
    if (bus.i_ret_valid !== 1'b1 || bus.i_ret_data !== 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000) begin
      n_fail++; $display("FAIL stall_line: got v=%b %h expected 1 dead0003dead0002dead0001dead0000", bus.i_ret_valid, bus.i_ret_data);
    end
    extra = 0;
    repeat (6) begin @(negedge clk); if (bus.i_ret_valid) extra++; end
    n_tests++;
    if (extra !== 0) begin n_fail++; $display("FAIL stall_ret_once: got %0d extra pulses expected 0", extra); end
  endtask

  task automatic test_rlast_err();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    n_tests++;
    if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL rlast_pre: got %b expected 0", bus.proto_err); end
    bus.i_rd_addr = 32'h4000_0020; bus.i_rd_req = 1;
    @(negedge clk);
    bus.i_rd_req = 0;
    axi_serve(0, 0, {32'h5, 32'h6, 32'h7, 32'h8}, 1, 2'b00, a, id, len, szb, lat, unst, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL rlast_timeout: arvalid never seen"); return; end
    n_tests++;
    if ({bus.i_ret_valid, bus.proto_err} !== 2'b11) begin n_fail++; $display("FAIL rlast_err: got ret/err %b expected 11", {bus.i_ret_valid, bus.proto_err}); end
    n_tests++;
    if (bus.i_ret_data !== 128'h00000005_00000006_00000007_00000008) begin n_fail++; $display("FAIL rlast_data: got %h expected 00000005000000060000000700000008", bus.i_ret_data); end
    @(negedge clk);
    bus.i_rd_req = 1;
    @(negedge clk);
    bus.i_rd_req = 0;
    axi_serve(0, 0, {32'h1, 32'h2, 32'h3, 32'h4}, 3, 2'b00, a, id, len, szb, lat, unst, to);
    n_tests++;
    if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL rlast_sticky: got %b expected 1", bus.proto_err); end
    @(negedge clk);
  endtask

  task automatic test_rresp_err();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    do_reset();
    bus.d_rd_addr = 32'h0000_0040; bus.d_rd_req = 1;
    @(negedge clk);
    bus.d_rd_req = 0;
    axi_serve(0, 0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 3, 2'b10, a, id, len, szb, lat, unst, to);
    n_tests++;
    if ({bus.d_ret_valid, bus.proto_err} !== 2'b11 || bus.d_ret_data !== 128'h000000C3_000000C2_000000C1_000000C0) begin
      n_fail++; $display("FAIL rresp_err: got ret/err %b data %h expected 11 000000c3000000c2000000c1000000c0", {bus.d_ret_valid, bus.proto_err}, bus.d_ret_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [4:0] szb; int lat, unst; bit to;
    int pulses;
    bus.i_rd_addr = 32'h2000_0008; bus.i_rd_req = 1;
    @(negedge clk);
    bus.i_rd_req = 0;
    bus.arready = 1;
    @(negedge clk);
    bus.arready = 0;
    bus.rvalid = 1; bus.rdata = 32'h0BAD_0000; bus.rlast = 0;
    @(negedge clk);
    bus.rdata = 32'h0BAD_0001;
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({bus.arvalid, bus.rready, bus.i_ret_valid, bus.d_ret_valid, bus.proto_err, bus.i_rd_rdy, bus.d_rd_rdy} !== 7'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got %b expected 0000000", {bus.arvalid, bus.rready, bus.i_ret_valid, bus.d_ret_valid, bus.proto_err, bus.i_rd_rdy, bus.d_rd_rdy});
    end
    n_tests++;
    if ({bus.i_ret_data, bus.d_ret_data} !== 256'h0) begin n_fail++; $display("FAIL midrst_data: got %h/%h expected 0", bus.i_ret_data, bus.d_ret_data); end
    bus.rvalid = 0; bus.rdata = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (bus.i_ret_valid || bus.d_ret_valid || bus.arvalid) pulses++; end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", pulses); end
    bus.i_rd_addr = 32'h2000_0008; bus.i_rd_req = 1;
    @(negedge clk);
    bus.i_rd_req = 0;
    axi_serve(0, 0, {32'h0F0F_0003, 32'h0F0F_0002, 32'h0F0F_0001, 32'h0F0F_0000}, 3, 2'b00, a, id, len, szb, lat, unst, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout: arvalid never seen"); return; end
    n_tests++;
    if (a !== 32'h2000_0000 || bus.i_ret_valid !== 1'b1 || bus.i_ret_data !== 128'h0F0F0003_0F0F0002_0F0F0001_0F0F0000) begin
      n_fail++; $display("FAIL midrst_fresh: got addr %h v=%b %h expected 20000000 1 0f0f00030f0f00020f0f00010f0f0000", a, bus.i_ret_valid, bus.i_ret_data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_refill();
    test_tie();
    test_stall();
    test_rlast_err();
    test_rresp_err();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
